// File: rtl/rw_seq_pkg.sv
// Shared types and helpers for the wr/rd strobe sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rw_seq_pkg;

  // Gap LFSR: 8-bit Galois, x^8+x^6+x^5+x^4+1, right-shifting form.
  localparam int          LFSR_W        = 8;
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
  localparam logic [7:0]  LFSR_SEED_DEF = 8'hA5;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_PULSE = 2'd1,
    WR_GAP   = 2'd2,
    WR_FIN   = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT   = 2'd1,
    RD_ACTIVE = 2'd2,
    RD_FIN    = 2'd3
  } rd_state_e;

  // Force a requested gap into the legal [mn, mx] window.
  function automatic int gap_clamp(input int v, input int mn, input int mx);
    if (v < mn) return mn;
    if (v > mx) return mx;
    return v;
  endfunction

  // Map a 4-bit LFSR nibble onto the legal [mn, mx] window.
  function automatic int gap_from_lfsr(input logic [3:0] nib, input int mn, input int mx);
    return mn + (int'(nib) % (mx - mn + 1));
  endfunction

endpackage

// File: rtl/rw_gap_lfsr.sv
// Free-running 8-bit Galois LFSR supplying pseudo-random gap lengths.
// Latency: advances one step every clk; state_o is the registered state.
// Backpressure: none, never stalls; reloads SEED only on rst.
// Ports: clk, rst (async active-high), state_o (current LFSR state).
module rw_gap_lfsr
  import rw_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/rw_strobe_sequencer.sv
// Stimulus stage: per run, NUM_TXN 1-cycle wr strobes and NUM_TXN RD_LEN-cycle rd bursts, then done.
// Latency: start sampled at edge 0 -> first wr / busy in cycle 1; all outputs registered.
// Backpressure: none; start is ignored unless both channels are idle and busy is low.
// Ports: clk, rst (async active-high), start, gap_mode, fixed_gap in; wr, rd, done, busy, wr_cnt, rd_cnt out.
module rw_strobe_sequencer
  import rw_seq_pkg::*;
#(
  parameter int               NUM_TXN   = 5,
  parameter int               RD_LEN    = 2,
  parameter int               MIN_GAP   = 1,
  parameter int               MAX_GAP   = 3,
  parameter int               GAP_W     = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             gap_mode,
  input  logic [GAP_W-1:0]                 fixed_gap,
  output logic                             wr,
  output logic                             rd,
  output logic                             done,
  output logic                             busy,
  output logic [$clog2(NUM_TXN+1)-1:0]     wr_cnt,
  output logic [$clog2(NUM_TXN+1)-1:0]     rd_cnt
);

  localparam int CNT_W = $clog2(NUM_TXN + 1);
  localparam int LEN_W = $clog2(RD_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_TXN = CNT_W'(NUM_TXN);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(RD_LEN);

  wr_state_e         wr_st_q, wr_st_d;
  rd_state_e         rd_st_q, rd_st_d;
  logic [GAP_W-1:0]  wr_gap_q, wr_gap_d;
  logic [GAP_W-1:0]  rd_gap_q, rd_gap_d;
  logic [GAP_W-1:0]  wr_gap_smp, rd_gap_smp;
  logic [LEN_W-1:0]  rd_len_q, rd_len_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              go_q, go_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              both_fin;
  logic [LFSR_W-1:0] lfsr;

  rw_gap_lfsr #(
    .SEED (LFSR_SEED)
  ) u_gap_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr)
  );

  // Gap value offered to each channel this cycle; only used on entry to GAP/WAIT,
  // so gap_mode/fixed_gap changes mid-run take effect from the next gap.
  always_comb begin
    if (gap_mode) begin
      wr_gap_smp = GAP_W'(gap_from_lfsr(lfsr[3:0], MIN_GAP, MAX_GAP));
      rd_gap_smp = GAP_W'(gap_from_lfsr(lfsr[7:4], MIN_GAP, MAX_GAP));
    end else begin
      wr_gap_smp = GAP_W'(gap_clamp(int'(fixed_gap), MIN_GAP, MAX_GAP));
      rd_gap_smp = wr_gap_smp;
    end
  end

  always_comb begin
    wr_st_d  = wr_st_q;
    rd_st_d  = rd_st_q;
    wr_gap_d = wr_gap_q;
    rd_gap_d = rd_gap_q;
    rd_len_d = rd_len_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    busy_d   = busy_q;

    both_fin = (wr_st_q == WR_FIN) && (rd_st_q == RD_FIN);

    // Accept lands in go_q first so the run becomes visible in cycle 1;
    // go_q also blocks a second accept while the channels are still IDLE.
    go_d = start && (wr_st_q == WR_IDLE) && (rd_st_q == RD_IDLE) && !busy_q && !go_q;

    unique case (wr_st_q)
      WR_IDLE: begin
        if (go_q) begin
          wr_st_d  = WR_PULSE;
          wr_cnt_d = CNT_W'(1);
        end
      end
      WR_PULSE: begin
        if (wr_cnt_q < LAST_TXN) begin
          wr_st_d  = WR_GAP;
          wr_gap_d = wr_gap_smp;
        end else begin
          wr_st_d = WR_FIN;
        end
      end
      WR_GAP: begin
        if (wr_gap_q <= GAP_W'(1)) begin
          wr_st_d  = WR_PULSE;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          wr_gap_d = wr_gap_q - GAP_W'(1);
        end
      end
      WR_FIN: begin
        if (both_fin) wr_st_d = WR_IDLE;
      end
      default: wr_st_d = WR_IDLE;
    endcase

    unique case (rd_st_q)
      RD_IDLE: begin
        if (go_q) begin
          rd_st_d  = RD_WAIT;
          rd_gap_d = rd_gap_smp;
          rd_cnt_d = '0;
        end
      end
      RD_WAIT: begin
        if (rd_gap_q <= GAP_W'(1)) begin
          rd_st_d  = RD_ACTIVE;
          rd_len_d = LEN_INIT;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          rd_gap_d = rd_gap_q - GAP_W'(1);
        end
      end
      RD_ACTIVE: begin
        if (rd_len_q <= LEN_W'(1)) begin
          if (rd_cnt_q < LAST_TXN) begin
            rd_st_d  = RD_WAIT;
            rd_gap_d = rd_gap_smp;
          end else begin
            rd_st_d = RD_FIN;
          end
        end else begin
          rd_len_d = rd_len_q - LEN_W'(1);
        end
      end
      RD_FIN: begin
        if (both_fin) rd_st_d = RD_IDLE;
      end
      default: rd_st_d = RD_IDLE;
    endcase

    if (go_q) begin
      busy_d = 1'b1;
    end else if (both_fin) begin
      busy_d = 1'b0;
    end

    // Outputs decode the next state so they appear registered with the state.
    wr_d   = (wr_st_d == WR_PULSE);
    rd_d   = (rd_st_d == RD_ACTIVE);
    done_d = (wr_st_d == WR_FIN) && (rd_st_d == RD_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st_q  <= WR_IDLE;
      rd_st_q  <= RD_IDLE;
      wr_gap_q <= '0;
      rd_gap_q <= '0;
      rd_len_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_st_q  <= wr_st_d;
      rd_st_q  <= rd_st_d;
      wr_gap_q <= wr_gap_d;
      rd_gap_q <= rd_gap_d;
      rd_len_q <= rd_len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
    end
  end

  assign wr     = wr_q;
  assign rd     = rd_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_rw_strobe_sequencer.sv
// Directed bench for rw_strobe_sequencer: per-cycle strobe masks against hand-derived cycle lists.
// Latency: cycle n is sampled on the falling edge after rising edge n (edge 0 samples start).
// Backpressure: n/a.
module tb_rw_strobe_sequencer;

  localparam int NUM_TXN = 5;
  localparam int RD_LEN  = 2;
  localparam int MIN_GAP = 1;
  localparam int MAX_GAP = 3;
  localparam int GAP_W   = 2;
  localparam int CNT_W   = $clog2(NUM_TXN + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic             gap_mode;
  logic [GAP_W-1:0] fixed_gap;
  logic             wr, rd, done, busy;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  logic [63:0] outv;
  assign outv = 64'({wr, rd, done, busy, wr_cnt, rd_cnt});

  rw_strobe_sequencer #(
    .NUM_TXN   (NUM_TXN),
    .RD_LEN    (RD_LEN),
    .MIN_GAP   (MIN_GAP),
    .MAX_GAP   (MAX_GAP),
    .GAP_W     (GAP_W),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gap_mode  (gap_mode),
    .fixed_gap (fixed_gap),
    .wr        (wr),
    .rd        (rd),
    .done      (done),
    .busy      (busy),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [63:0]      wr_m, rd_m, done_m, busy_m;
  logic [CNT_W-1:0] wc_h [0:63];
  logic [CNT_W-1:0] rc_h [0:63];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Called at a falling edge; raises start for edge 0 and records cycles 0..ncyc.
  task automatic run_cap(input int ncyc, input logic hold);
    wr_m = '0; rd_m = '0; done_m = '0; busy_m = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clk);
      wr_m[n]   = wr;
      rd_m[n]   = rd;
      done_m[n] = done;
      busy_m[n] = busy;
      wc_h[n]   = wr_cnt;
      rc_h[n]   = rd_cnt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Idle cycles between consecutive wr pulses that fall outside [MIN_GAP, MAX_GAP].
  task automatic wr_gap_check(input logic [63:0] m, output int viol);
    int last;
    last = -1;
    viol = 0;
    for (int i = 0; i < 64; i++) begin
      if (m[i]) begin
        if (last >= 0 && ((i - last - 1) < MIN_GAP || (i - last - 1) > MAX_GAP)) viol++;
        last = i;
      end
    end
  endtask

  // Read waits start in cycle 1, so the first burst's lead-in is measured from cycle 0.
  task automatic rd_shape(input logic [63:0] m, output int bursts, output int len_viol,
                          output int gap_viol);
    int run_len;
    int last_end;
    run_len = 0; last_end = 0; bursts = 0; len_viol = 0; gap_viol = 0;
    for (int i = 0; i < 64; i++) begin
      if (m[i]) begin
        if (run_len == 0) begin
          bursts++;
          if ((i - last_end - 1) < MIN_GAP || (i - last_end - 1) > MAX_GAP) gap_viol++;
        end
        run_len++;
      end else if (run_len > 0) begin
        if (run_len != RD_LEN) len_viol++;
        run_len  = 0;
        last_end = i - 1;
      end
    end
  endtask

  logic [63:0] e_wr1, e_rd1, e_done1, e_busy1;
  logic [63:0] r_wr, r_rd, r_done;
  int          cnt, dpos, v1, v2, v3;
  logic        seen;

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; gap_mode = 1'b0; fixed_gap = 2'd2;

    // Reset applied before any clock edge must clear outputs on its own.
    #2 chk("rst_async_at_t0", outv, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_outs", outv, 64'd0);

    // fixed_gap = 2
    e_wr1   = rng(1,1) | rng(4,4) | rng(7,7) | rng(10,10) | rng(13,13);
    e_rd1   = rng(3,4) | rng(7,8) | rng(11,12) | rng(15,16) | rng(19,20);
    e_done1 = rng(21,21);
    e_busy1 = rng(1,21);
    run_cap(23, 1'b0);
    chk("g2_wr",        wr_m,   e_wr1);
    chk("g2_rd",        rd_m,   e_rd1);
    chk("g2_done",      done_m, e_done1);
    chk("g2_busy",      busy_m, e_busy1);
    chk("g2_wrcnt_c1",  64'(wc_h[1]), 64'd1);
    chk("g2_rdcnt_c2",  64'(rc_h[2]), 64'd0);
    chk("g2_rdcnt_c3",  64'(rc_h[3]), 64'd1);
    chk("g2_wrcnt_end", 64'(wc_h[23]), 64'd5);
    chk("g2_rdcnt_end", 64'(rc_h[23]), 64'd5);
    repeat (3) @(negedge clk);
    chk("g2_cnt_hold",  64'({wr_cnt, rd_cnt}), 64'({3'd5, 3'd5}));

    // fixed_gap = 0 clamps up to MIN_GAP = 1
    fixed_gap = 2'd0;
    run_cap(18, 1'b0);
    chk("g0_wr",   wr_m,   rng(1,1) | rng(3,3) | rng(5,5) | rng(7,7) | rng(9,9));
    chk("g0_rd",   rd_m,   rng(2,3) | rng(5,6) | rng(8,9) | rng(11,12) | rng(14,15));
    chk("g0_done", done_m, rng(16,16));
    chk("g0_busy", busy_m, rng(1,16));
    chk("g0_cnt",  64'({wc_h[18], rc_h[18]}), 64'({3'd5, 3'd5}));
    repeat (2) @(negedge clk);

    // start held high for the whole run: no restart until after done, then a fresh run.
    fixed_gap = 2'd2;
    run_cap(25, 1'b1);
    chk("hold_wr",     wr_m,   e_wr1 | rng(24,24));
    chk("hold_rd",     rd_m,   e_rd1);
    chk("hold_done",   done_m, e_done1);
    chk("hold_busy",   busy_m, e_busy1 | rng(24,25));
    chk("hold_wrcnt_c23", 64'(wc_h[23]), 64'd5);
    chk("hold_wrcnt_c24", 64'(wc_h[24]), 64'd1);
    chk("hold_rdcnt_c24", 64'(rc_h[24]), 64'd0);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("hold_second_done", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in cycle 8 of a fixed_gap = 2 run.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_pre_state", 64'({rd, busy, wr_cnt, rd_cnt}), 64'({1'b1, 1'b1, 3'd3, 3'd2}));
    #1 rst = 1'b1;
    #1 chk("mid_async_clear", outv, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("mid_no_done_busy", 64'(cnt), 64'd0);
    run_cap(23, 1'b0);
    chk("mid_rerun_wr",   wr_m,   e_wr1);
    chk("mid_rerun_rd",   rd_m,   e_rd1);
    chk("mid_rerun_done", done_m, e_done1);

    // LFSR gaps: two runs, each started the same number of cycles after reset.
    gap_mode = 1'b1;
    do_reset();
    run_cap(35, 1'b0);
    r_wr = wr_m; r_rd = rd_m; r_done = done_m;
    chk("rnd_wr_first",  64'(wr_m[1]), 64'd1);
    chk("rnd_wr_count",  64'($countones(wr_m)), 64'd5);
    wr_gap_check(wr_m, v1);
    chk("rnd_wr_gap_viol", 64'(v1), 64'd0);
    rd_shape(rd_m, v1, v2, v3);
    chk("rnd_rd_bursts",   64'(v1), 64'd5);
    chk("rnd_rd_len_viol", 64'(v2), 64'd0);
    chk("rnd_rd_gap_viol", 64'(v3), 64'd0);
    chk("rnd_done_count",  64'($countones(done_m)), 64'd1);
    dpos = 0;
    for (int i = 0; i < 64; i++) if (done_m[i]) dpos = i;
    chk("rnd_busy_span", busy_m, rng(1, dpos));
    chk("rnd_cnt_end", 64'({wc_h[35], rc_h[35]}), 64'({3'd5, 3'd5}));
    do_reset();
    run_cap(35, 1'b0);
    chk("rnd_repeat_wr",   wr_m,   r_wr);
    chk("rnd_repeat_rd",   rd_m,   r_rd);
    chk("rnd_repeat_done", done_m, r_done);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
